dds_multi_voice: RTL and testbench

- Multi-voice direct-digital-synthesis tone generator for the audio path.
- Each voice has a phase accumulator and can produce a sine, square, triangle or sawtooth wave.
- The sine comes from a generated quarter-wave ROM, mirrored to the full wave.
- Voices are computed time-multiplexed once per sample_tick; their sum is handed to the audio sink over a valid/ready handshake.

---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_quarter_rom.sv | 29 ++
 rtl/dds_multi_voice.sv | 188 ++++++++++++++++++
 tb/tb_dds_multi_voice.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared encodings and width helpers for the multi-voice DDS
package dds_pkg;

    typedef enum logic [1:0] {
        WAVE_SINE   = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SAW    = 2'd3
    } wave_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_SHAPE = 2'd2,
        ST_OUT   = 2'd3
    } state_e;

    // A single voice still needs a one-bit index register.
    function automatic int idx_width(input int num_voices);
        return (num_voices > 1) ? $clog2(num_voices) : 1;
    endfunction

    function automatic int sum_width(input int out_w, input int num_voices);
        return out_w + $clog2(num_voices);
    endfunction

endpackage

// File: rtl/dds_quarter_rom.sv
// rtl/dds_quarter_rom.sv - quarter-wave sine table, Q+1 entries, one-cycle registered read
module dds_quarter_rom #(
    parameter int LUT_ADDR_W = 8,
    parameter int AMP_LOG2   = 10
) (
    input  logic                  clk_i,
    input  logic [LUT_ADDR_W-2:0] addr_i,
    output logic [AMP_LOG2:0]     data_o
);

    localparam int  Q  = 1 << (LUT_ADDR_W - 2);
    localparam real PI = 3.14159265358979323846;

    logic [AMP_LOG2:0] table_w [Q+1];
    logic [AMP_LOG2:0] data_q;

    // Entry Q reaches the full amplitude, hence the extra output bit.
    for (genvar k = 0; k <= Q; k++) begin : g_entry
        localparam int VALUE = $rtoi(real'(1 << AMP_LOG2) * $sin(PI * k / (2.0 * Q)) + 0.5);
        assign table_w[k] = VALUE[AMP_LOG2:0];
    end

    always_ff @(posedge clk_i) begin
        data_q <= table_w[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/dds_multi_voice.sv
// rtl/dds_multi_voice.sv - time-multiplexed multi-voice DDS tone generator with summed output
module dds_multi_voice
    import dds_pkg::*;
#(
    parameter  int NUM_VOICES = 4,
    parameter  int PHASE_W    = 24,
    parameter  int LUT_ADDR_W = 8,
    parameter  int AMP_LOG2   = 10,
    parameter  int OUT_W      = 14,
    localparam int IDX_W      = idx_width(NUM_VOICES),
    localparam int SUM_W      = sum_width(OUT_W, NUM_VOICES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_tick,
    input  logic                    fcw_wr_en,
    input  logic [IDX_W-1:0]        fcw_wr_idx,
    input  logic [PHASE_W-1:0]      fcw_wr_data,
    input  logic [NUM_VOICES-1:0]   voice_en,
    input  logic [1:0]              wave_sel,
    input  logic                    phase_clr,
    output logic signed [SUM_W-1:0] sample_out,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    busy,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int Q      = 1 << (LUT_ADDR_W - 2);
    localparam int ROM_AW = LUT_ADDR_W - 1;
    localparam int ROM_DW = AMP_LOG2 + 1;
    localparam int TRI_SH = AMP_LOG2 - (LUT_ADDR_W - 2);
    localparam int SAW_SH = AMP_LOG2 - (LUT_ADDR_W - 1);
    localparam int SAW_L  = (SAW_SH > 0) ? SAW_SH : 0;
    localparam int SAW_R  = (SAW_SH < 0) ? 1 : 0;
    localparam logic [ROM_AW-1:0]      Q_ADDR = ROM_AW'(Q);
    localparam logic signed [OUT_W-1:0] AMP   = OUT_W'(1 << AMP_LOG2);

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           v_q, v_d;
    logic signed [SUM_W-1:0]    sum_q, sum_d;
    logic                       overrun_q, overrun_d;

    logic [PHASE_W-1:0]         phase_q    [NUM_VOICES];
    logic [PHASE_W-1:0]         fcw_pend_q [NUM_VOICES];
    logic [PHASE_W-1:0]         fcw_act_q  [NUM_VOICES];

    logic [LUT_ADDR_W-1:0]      a_q;
    wave_e                      wave_q;
    logic                       en_q;

    logic                       tick_accept;
    logic                       cur_en;
    logic [PHASE_W-1:0]         new_phase;
    logic [LUT_ADDR_W-1:0]      new_a;
    logic [ROM_AW-1:0]          rom_addr;
    logic [ROM_DW-1:0]          rom_data;

    logic [1:0]                 quad;
    logic [LUT_ADDR_W-3:0]      m;
    logic signed [OUT_W-1:0]    rom_s, tri_t, saw_x, val, voice_val;

    // Phase update and ROM address for the voice in its ACC cycle.
    always_comb begin
        tick_accept = (state_q == ST_IDLE) && sample_tick;
        cur_en      = voice_en[v_q];
        new_phase   = cur_en ? phase_q[v_q] + fcw_act_q[v_q] : phase_q[v_q];
        new_a       = new_phase[PHASE_W-1 -: LUT_ADDR_W];
        if (new_a[LUT_ADDR_W-2])
            rom_addr = Q_ADDR - {1'b0, new_a[LUT_ADDR_W-3:0]};
        else
            rom_addr = {1'b0, new_a[LUT_ADDR_W-3:0]};
    end

    dds_quarter_rom #(
        .LUT_ADDR_W (LUT_ADDR_W),
        .AMP_LOG2   (AMP_LOG2)
    ) u_rom (
        .clk_i  (clk),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    // Waveform shaping in the SHAPE cycle from the phase latched during ACC.
    always_comb begin
        quad  = a_q[LUT_ADDR_W-1 -: 2];
        m     = a_q[LUT_ADDR_W-3:0];
        rom_s = signed'(OUT_W'(rom_data));
        tri_t = signed'(OUT_W'(m)) <<< TRI_SH;
        saw_x = OUT_W'(signed'({~a_q[LUT_ADDR_W-1], a_q[LUT_ADDR_W-2:0]}));
        val   = '0;
        case (wave_q)
            WAVE_SINE:   val = quad[1] ? -rom_s : rom_s;
            WAVE_SQUARE: val = quad[1] ? -AMP : AMP;
            WAVE_TRI: begin
                case (quad)
                    2'd0:    val = tri_t;
                    2'd1:    val = AMP - tri_t;
                    2'd2:    val = -tri_t;
                    default: val = tri_t - AMP;
                endcase
            end
            default:     val = (saw_x <<< SAW_L) >>> SAW_R;
        endcase
        voice_val = en_q ? val : '0;
    end

    always_comb begin
        state_d   = state_q;
        v_d       = v_q;
        sum_d     = sum_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    sum_d   = '0;
                    v_d     = '0;
                    state_d = ST_ACC;
                end
            end
            ST_ACC: state_d = ST_SHAPE;
            ST_SHAPE: begin
                sum_d = sum_q + SUM_W'(voice_val);
                if (v_q == IDX_W'(NUM_VOICES - 1)) begin
                    state_d = ST_OUT;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = ST_ACC;
                end
            end
            default: begin
                if (sample_ready) state_d = ST_IDLE;
            end
        endcase
        // A new drop outranks a simultaneous clear.
        if (sample_tick && (state_q != ST_IDLE))
            overrun_d = 1'b1;
        else if (overrun_clr)
            overrun_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            v_q       <= '0;
            sum_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            sum_q     <= sum_d;
            overrun_q <= overrun_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]    <= '0;
                fcw_pend_q[i] <= '0;
                fcw_act_q[i]  <= '0;
            end
            a_q    <= '0;
            wave_q <= WAVE_SINE;
            en_q   <= 1'b0;
        end else begin
            if (fcw_wr_en) fcw_pend_q[fcw_wr_idx] <= fcw_wr_data;
            if (tick_accept) fcw_act_q <= fcw_pend_q;
            // Clearing in IDLE precedes the first ACC, so a coincident tick accumulates from zero.
            if ((state_q == ST_IDLE) && phase_clr) begin
                for (int i = 0; i < NUM_VOICES; i++) phase_q[i] <= '0;
            end
            if (state_q == ST_ACC) begin
                phase_q[v_q] <= new_phase;
                a_q          <= new_a;
                wave_q       <= wave_e'(wave_sel);
                en_q         <= cur_en;
            end
        end
    end

    assign sample_out   = sum_q;
    assign sample_valid = (state_q == ST_OUT);
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_dds_multi_voice.sv
// tb/tb_dds_multi_voice.sv - randomized self-checking bench for dds_multi_voice
module tb_dds_multi_voice;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               sample_tick = 1'b0;
    logic               fcw_wr_en = 1'b0;
    logic [1:0]         fcw_wr_idx = '0;
    logic [23:0]        fcw_wr_data = '0;
    logic [3:0]         voice_en = '0;
    logic [1:0]         wave_sel = '0;
    logic               phase_clr = 1'b0;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               sample_ready = 1'b1;
    logic               busy;
    logic               overrun;
    logic               overrun_clr = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    longint unsigned phase_m [4];
    longint unsigned pend_m  [4];
    longint unsigned act_m   [4];
    int last_got;
    int last_exp;

    dds_multi_voice dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_tick  (sample_tick),
        .fcw_wr_en    (fcw_wr_en),
        .fcw_wr_idx   (fcw_wr_idx),
        .fcw_wr_data  (fcw_wr_data),
        .voice_en     (voice_en),
        .wave_sel     (wave_sel),
        .phase_clr    (phase_clr),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .busy         (busy),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rom_ref(input int k);
        return $rtoi(1024.0 * $sin(3.14159265358979323846 * k / 128.0) + 0.5);
    endfunction

    // Voice value straight from the waveform definitions: a in 0..255, Q=64, A=1024.
    function automatic int wave_ref(input int a, input int w);
        int quad, m, t;
        quad = a / 64;
        m    = a % 64;
        t    = m * 16;
        case (w)
            0: case (quad)
                   0: return rom_ref(m);
                   1: return rom_ref(64 - m);
                   2: return -rom_ref(m);
                   default: return -rom_ref(64 - m);
               endcase
            1: return (a < 128) ? 1024 : -1024;
            2: case (quad)
                   0: return t;
                   1: return 1024 - t;
                   2: return -t;
                   default: return t - 1024;
               endcase
            default: return (a - 128) * 8;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            phase_m[i] = 0;
            pend_m[i]  = 0;
            act_m[i]   = 0;
        end
    endtask

    task automatic model_tick(output int exp);
        exp = 0;
        for (int i = 0; i < 4; i++) act_m[i] = pend_m[i];
        if (phase_clr)
            for (int i = 0; i < 4; i++) phase_m[i] = 0;
        for (int v = 0; v < 4; v++) begin
            if (voice_en[v]) begin
                phase_m[v] = (phase_m[v] + act_m[v]) % 64'd16777216;
                exp += wave_ref(int'(phase_m[v] >> 16), int'(wave_sel));
            end
        end
    endtask

    task automatic write_fcw(input int idx, input longint unsigned val);
        fcw_wr_en   = 1'b1;
        fcw_wr_idx  = 2'(idx);
        fcw_wr_data = 24'(val);
        @(negedge clk);
        fcw_wr_en   = 1'b0;
        pend_m[idx] = val;
    endtask

    // One full sample; optionally rewrite voice 1's FCW and pulse phase_clr while busy.
    task automatic run_sample(input string tag, input bit mid_write, input longint unsigned mid_fcw);
        int exp, cyc;
        model_tick(exp);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        phase_clr   = 1'b0;
        cyc = 1;
        while (!sample_valid && cyc < 40) begin
            if (mid_write && cyc == 3) begin
                fcw_wr_en   = 1'b1;
                fcw_wr_idx  = 2'd1;
                fcw_wr_data = 24'(mid_fcw);
                phase_clr   = 1'b1;
            end else begin
                fcw_wr_en   = 1'b0;
                phase_clr   = 1'b0;
            end
            @(negedge clk);
            if (mid_write && cyc == 3) pend_m[1] = mid_fcw;
            cyc++;
        end
        fcw_wr_en = 1'b0;
        phase_clr = 1'b0;
        check({tag, "_lat"}, cyc, 9);
        check({tag, "_out"}, sample_out, exp);
        last_got = int'(sample_out);
        last_exp = exp;
        if (sample_ready) begin
            @(negedge clk);
            check({tag, "_done"}, sample_valid, 0);
        end
    endtask

    initial begin
        int wait_cyc;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", sample_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_out", sample_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single sine voice stepping a by one per tick.
        write_fcw(0, 24'h010000);
        voice_en = 4'b0001;
        wave_sel = 2'd0;
        for (int k = 1; k <= 129; k++) begin
            run_sample("sine", 1'b0, 0);
            if (k == 1)   check("sine_t1", last_got, 25);
            if (k == 64)  check("sine_t64", last_got, 1024);
            if (k == 128) check("sine_t128", last_got, 0);
            if (k == 129) check("sine_t129", last_got, -25);
        end

        // Quarter-turn steps through every waveform.
        write_fcw(0, 24'h400000);
        for (int w = 1; w < 4; w++) begin
            wave_sel  = 2'(w);
            phase_clr = 1'b1;
            for (int k = 0; k < 4; k++) run_sample($sformatf("wave%0d", w), 1'b0, 0);
        end

        // All voices, then voice 2 disabled and re-enabled.
        for (int i = 0; i < 4; i++) write_fcw(i, 24'h400000);
        wave_sel  = 2'd0;
        voice_en  = 4'hF;
        phase_clr = 1'b1;
        run_sample("all4", 1'b0, 0);
        check("all4_sum", last_got, 4096);
        voice_en = 4'b1011;
        run_sample("dis2", 1'b0, 0);
        check("dis2_sum", last_got, 0);
        voice_en = 4'hF;
        run_sample("reen2", 1'b0, 0);

        // Backpressure and overrun.
        sample_ready = 1'b0;
        run_sample("bp", 1'b0, 0);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        check("ovr_set", overrun, 1);
        check("ovr_valid_held", sample_valid, 1);
        check("ovr_out_held", sample_out, last_exp);
        sample_tick = 1'b1;
        overrun_clr = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        overrun_clr = 1'b0;
        check("ovr_set_wins", overrun, 1);
        sample_ready = 1'b1;
        @(negedge clk);
        check("bp_done_valid", sample_valid, 0);
        check("bp_done_busy", busy, 0);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", overrun, 0);

        // FCW write and phase_clr while busy.
        run_sample("midwr", 1'b1, 24'h123456);
        run_sample("midwr_next", 1'b0, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int j = 0; j < nw; j++) write_fcw($urandom_range(0, 3), longint'($urandom) & 64'hFFFFFF);
            voice_en  = 4'($urandom);
            wave_sel  = 2'($urandom);
            phase_clr = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_sample($sformatf("rnd%0d", n), 1'b0, 0);
        end

        // Asynchronous reset during SHAPE of voice 2.
        voice_en = 4'hF;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        wait_cyc = 1;
        while (wait_cyc < 6) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("arst_valid", sample_valid, 0);
        check("arst_busy", busy, 0);
        check("arst_out", sample_out, 0);
        check("arst_overrun", overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        write_fcw(0, 24'h010000);
        voice_en = 4'b0001;
        wave_sel = 2'd0;
        run_sample("post_rst", 1'b0, 0);
        check("post_rst_25", last_got, 25);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
